c432_key_ctrl: RTL and testbench

C432_KEY_CTRL -- requirements
Module: c432_key_ctrl

---
 rtl/c432_key_ctrl.sv | 124 ++++++++++++
 tb/tb_c432_key_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c432_key_ctrl.sv
// Key-load controller for a logic-locked c432 core: receives a 14-bit serial
// frame (13 key bits + even parity), commits it, and flags when outputs settle.
module c432_key_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_FAIL      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        zeroize,
  input  logic        sdata_valid,
  input  logic        sdata,
  output logic        sdata_ready,
  output logic [12:0] key,
  output logic        key_valid,
  output logic        busy,
  output logic        err_parity,
  output logic        locked
);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_CHECK, S_SETTLE, S_ACTIVE, S_LOCKOUT
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [13:0] r_shadow;
  logic [3:0]  r_cnt;
  logic [3:0]  r_settle_cnt;
  logic [2:0]  r_fail;
  logic [12:0] r_key;
  logic        r_key_valid;
  logic        r_err_parity;
  logic        r_locked;
  logic [2:0]  w_fail_inc;
  logic        w_parity_ok;
  logic        w_frame_bad;

  assign w_fail_inc  = r_fail + 3'd1;
  assign w_parity_ok = ~(^r_shadow);
  // Parity of the frame as it completes: stored bits 0..12 plus the incoming parity beat.
  assign w_frame_bad = ^{r_shadow[12:0], sdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_SHIFT;
      S_SHIFT:  if (sdata_valid && (r_cnt == 4'd13)) w_state_next = S_CHECK;
      S_CHECK: begin
        if (w_parity_ok)                       w_state_next = S_SETTLE;
        else if (w_fail_inc == 3'(MAX_FAIL))   w_state_next = S_LOCKOUT;
        else                                   w_state_next = S_IDLE;
      end
      S_SETTLE: if (r_settle_cnt == 4'(SETTLE_CYCLES - 1)) w_state_next = S_ACTIVE;
      S_ACTIVE: if (start) w_state_next = S_SHIFT;
      default:  w_state_next = S_LOCKOUT;
    endcase
    // Zeroize overrides everything except the lockout trap.
    if (zeroize && (r_state != S_LOCKOUT)) w_state_next = S_IDLE;
  end

  always_comb begin
    sdata_ready = (r_state == S_SHIFT);
    busy        = (r_state == S_SHIFT) || (r_state == S_CHECK) || (r_state == S_SETTLE);
    key         = r_key;
    key_valid   = r_key_valid;
    err_parity  = r_err_parity;
    locked      = r_locked;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow     <= '0;
      r_cnt        <= '0;
      r_settle_cnt <= '0;
      r_fail       <= '0;
      r_key        <= '0;
      r_key_valid  <= 1'b0;
      r_err_parity <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      // Status flags are registered copies of where the FSM is heading.
      r_key_valid  <= (w_state_next == S_ACTIVE);
      r_locked     <= (w_state_next == S_LOCKOUT);
      r_err_parity <= (w_state_next == S_CHECK) && w_frame_bad;
      if (zeroize) begin
        r_key    <= '0;
        r_shadow <= '0;
        r_cnt    <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_ACTIVE: if (start) r_cnt <= '0;
          S_SHIFT: begin
            if (sdata_valid) begin
              r_shadow[r_cnt] <= sdata;
              r_cnt           <= r_cnt + 4'd1;
            end
          end
          S_CHECK: begin
            r_settle_cnt <= '0;
            if (w_parity_ok) begin
              r_key  <= r_shadow[12:0];
              r_fail <= '0;
            end else begin
              r_fail <= w_fail_inc;
              if (w_fail_inc == 3'(MAX_FAIL)) r_key <= '0;
            end
          end
          S_SETTLE: r_settle_cnt <= r_settle_cnt + 4'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_c432_key_ctrl.sv
// Self-checking bench for c432_key_ctrl: directed vector table, corner-case
// sequences, and randomized frames checked against a frame-level model.
module tb_c432_key_ctrl;

  localparam int SETTLE = 4;
  localparam int MAXF   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        zeroize = 1'b0;
  logic        sdata_valid = 1'b0;
  logic        sdata = 1'b0;
  logic        sdata_ready;
  logic [12:0] key;
  logic        key_valid;
  logic        busy;
  logic        err_parity;
  logic        locked;

  int checks = 0;
  int errors = 0;
  logic [12:0] cur_key = '0;

  c432_key_ctrl #(.SETTLE_CYCLES(SETTLE), .MAX_FAIL(MAXF)) dut (
    .clk(clk), .rst(rst), .start(start), .zeroize(zeroize),
    .sdata_valid(sdata_valid), .sdata(sdata), .sdata_ready(sdata_ready),
    .key(key), .key_valid(key_valid), .busy(busy),
    .err_parity(err_parity), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] k;
    bit          good;
    int          gap;
    bit          e_err;
    logic [12:0] e_key;
    bit          e_valid;
    bit          e_locked;
  } vec_t;

  vec_t tbl[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Even-parity bit that makes the 14-bit frame XOR to zero.
  function automatic logic even_par(input logic [12:0] k);
    int ones = 0;
    for (int i = 0; i < 13; i++) ones += int'(k[i]);
    return logic'(ones % 2);
  endfunction

  function automatic logic [13:0] make_frame(input logic [12:0] k, input bit good);
    logic [13:0] f;
    f[12:0] = k;
    f[13]   = good ? even_par(k) : ~even_par(k);
    return f;
  endfunction

  task automatic send_beats(input logic [13:0] fr, input int n, input int maxgap, input bit rnd);
    int g;
    for (int i = 0; i < n; i++) begin
      g = rnd ? int'($urandom_range(0, maxgap)) : maxgap;
      repeat (g) tick();
      sdata_valid = 1'b1;
      sdata       = fr[i];
      tick();
      sdata_valid = 1'b0;
      sdata       = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    cur_key = '0;
  endtask

  task automatic run_frame(input logic [12:0] k, input bit good, input int maxgap, input bit rnd,
                           input bit e_err, input logic [12:0] e_key, input bit e_valid,
                           input bit e_locked);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ready_in_shift", sdata_ready, 1);
    chk("key_held_during_load", key, cur_key);
    chk("valid_low_during_load", key_valid, 0);
    send_beats(make_frame(k, good), 14, maxgap, rnd);
    chk("err_parity_in_check", err_parity, e_err);
    chk("ready_low_in_check", sdata_ready, 0);
    tick();
    chk("key_after_check", key, e_key);
    chk("locked_after_check", locked, e_locked);
    chk("err_parity_one_cycle", err_parity, 0);
    chk("valid_low_after_check", key_valid, 0);
    if (e_valid) begin
      repeat (SETTLE - 1) tick();
      chk("valid_low_last_settle", key_valid, 0);
      chk("busy_in_settle", busy, 1);
      tick();
      chk("valid_first_active", key_valid, 1);
      chk("busy_low_active", busy, 0);
    end else begin
      chk("busy_low_after_reject", busy, 0);
    end
    cur_key = e_key;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_key"}, key, 0);
    chk({tag, "_key_valid"}, key_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sdata_ready"}, sdata_ready, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err_parity"}, err_parity, 0);
  endtask

  task automatic chk_lockout_sticky();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lock_start_ignored_ready", sdata_ready, 0);
    chk("lock_start_ignored_busy", busy, 0);
    chk("lock_locked", locked, 1);
    chk("lock_key_zero", key, 0);
    chk("lock_valid_zero", key_valid, 0);
  endtask

  logic [12:0] m_key;
  int          m_fail;
  bit          m_locked;

  initial begin
    tbl[0] = '{13'h0A5B, 1'b0, 0, 1'b1, 13'h0000, 1'b0, 1'b0};
    tbl[1] = '{13'h0A5B, 1'b1, 0, 1'b0, 13'h0A5B, 1'b1, 1'b0};
    tbl[2] = '{13'h1FFF, 1'b1, 3, 1'b0, 13'h1FFF, 1'b1, 1'b0};
    tbl[3] = '{13'h0A5B, 1'b1, 5, 1'b0, 13'h0A5B, 1'b1, 1'b0};
    tbl[4] = '{13'h1234, 1'b0, 2, 1'b1, 13'h0A5B, 1'b0, 1'b0};
    tbl[5] = '{13'h0000, 1'b0, 1, 1'b1, 13'h0A5B, 1'b0, 1'b0};
    tbl[6] = '{13'h0001, 1'b1, 0, 1'b0, 13'h0001, 1'b1, 1'b0};
    tbl[7] = '{13'h1555, 1'b0, 0, 1'b1, 13'h0001, 1'b0, 1'b0};
    tbl[8] = '{13'h0AAA, 1'b0, 1, 1'b1, 13'h0001, 1'b0, 1'b0};
    tbl[9] = '{13'h1FFF, 1'b0, 0, 1'b1, 13'h0000, 1'b0, 1'b1};

    do_reset();
    chk_all_zero("reset");

    for (int i = 0; i < 10; i++) begin
      run_frame(tbl[i].k, tbl[i].good, tbl[i].gap, 1'b0,
                tbl[i].e_err, tbl[i].e_key, tbl[i].e_valid, tbl[i].e_locked);
      $display("vec %0d key=0x%04h good=%0d -> key=0x%04h err_seen locked=%0d",
               i, tbl[i].k, tbl[i].good, key, locked);
    end
    chk_lockout_sticky();
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    chk("zeroize_in_lockout_stays", locked, 1);
    do_reset();
    chk("rst_clears_locked", locked, 0);

    // Reload from ACTIVE keeps the old key visible, then zeroize wipes it.
    run_frame(13'h0A5B, 1'b1, 0, 1'b0, 1'b0, 13'h0A5B, 1'b1, 1'b0);
    run_frame(13'h1FFF, 1'b1, 0, 1'b0, 1'b0, 13'h1FFF, 1'b1, 1'b0);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    chk_all_zero("zeroize_active");
    cur_key = '0;
    $display("seq reload+zeroize key=0x%04h", key);

    // Zeroize and start together: no load begins.
    run_frame(13'h0A5B, 1'b1, 1, 1'b0, 1'b0, 13'h0A5B, 1'b1, 1'b0);
    zeroize = 1'b1;
    start   = 1'b1;
    tick();
    zeroize = 1'b0;
    start   = 1'b0;
    chk_all_zero("zeroize_start");
    tick();
    chk("zeroize_start_no_shift", sdata_ready, 0);
    cur_key = '0;
    $display("seq zeroize+start ready=%0d", sdata_ready);

    // Asynchronous reset after seven beats.
    run_frame(13'h0A5B, 1'b1, 0, 1'b0, 1'b0, 13'h0A5B, 1'b1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_beats(make_frame(13'h1FFF, 1'b1), 7, 2, 1'b1);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("rst_waits_for_start", sdata_ready, 0);
    cur_key = '0;
    run_frame(13'h0A5B, 1'b1, 5, 1'b1, 1'b0, 13'h0A5B, 1'b1, 1'b0);
    $display("seq rst mid-frame reload key=0x%04h", key);

    // Zeroize mid-frame discards the partial frame and count.
    start = 1'b1;
    tick();
    start = 1'b0;
    send_beats(make_frame(13'h1111, 1'b1), 5, 0, 1'b0);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    chk_all_zero("zeroize_shift");
    cur_key = '0;
    run_frame(13'h1234, 1'b1, 1, 1'b0, 1'b0, 13'h1234, 1'b1, 1'b0);
    $display("seq zeroize mid-frame key=0x%04h", key);

    // Fail counter survives zeroize.
    do_reset();
    run_frame(13'h0123, 1'b0, 0, 1'b0, 1'b1, 13'h0000, 1'b0, 1'b0);
    run_frame(13'h0456, 1'b0, 0, 1'b0, 1'b1, 13'h0000, 1'b0, 1'b0);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    run_frame(13'h0789, 1'b0, 0, 1'b0, 1'b1, 13'h0000, 1'b0, 1'b1);
    $display("seq fail count across zeroize locked=%0d", locked);
    do_reset();

    // Randomized frames against the frame-level model.
    m_key = '0;
    m_fail = 0;
    m_locked = 1'b0;
    for (int it = 0; it < 40; it++) begin
      logic [12:0] k;
      bit          good;
      bit          e_err;
      k    = 13'($urandom);
      good = ($urandom % 4) != 0;
      if (($urandom % 8) == 0) begin
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        m_key   = '0;
        cur_key = '0;
        chk("rand_zeroize_key", key, 0);
      end
      e_err = !good;
      if (good) begin
        m_key  = k;
        m_fail = 0;
      end else begin
        m_fail++;
        if (m_fail == MAXF) begin
          m_locked = 1'b1;
          m_key    = '0;
        end
      end
      run_frame(k, good, 3, 1'b1, e_err, m_key, good, m_locked);
      $display("rand %0d key=0x%04h good=%0d -> key=0x%04h locked=%0d",
               it, k, good, key, locked);
      if (m_locked) begin
        chk_lockout_sticky();
        do_reset();
        m_key    = '0;
        m_fail   = 0;
        m_locked = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
